// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO controller for a 16x8 single-port BRAM with a
// one-cycle read latency. It has a valid/ready write stream, a one-word output
// register, and a three-state read FSM that fetches the oldest word.
module bram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   level,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(1 << ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                fetch;
    logic                wr_fire;

    // Arbitration, BRAM port drive and next-state logic. A pending fetch in
    // S_IDLE always owns the port, so a write never coincides with a fetch.
    always_comb begin
        fetch    = rst_n && (state_q == S_IDLE) && (level_q != '0);
        wr_ready = rst_n && (level_q < FULL_LEVEL)
                   && !((state_q == S_IDLE) && (level_q != '0));
        wr_fire  = wr_valid && wr_ready;

        mem_cs   = fetch || wr_fire;
        mem_we   = wr_fire;
        mem_addr = fetch ? rd_ptr_q : wr_ptr_q;
        mem_din  = wr_data;

        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (fetch) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                rd_data_d = mem_dout;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (rd_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fetch) begin
            level_d = level_q - 1'b1;
        end else if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            level_d  = level_q + 1'b1;
        end

        rd_valid = (state_q == S_HOLD);
        rd_data  = rd_data_q;
        level    = level_q;
    end

    // State registers; reset discards any in-flight fetch and the output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: scoreboard bench for bram_fifo_ctrl with a behavioural
// 16x8 BRAM model. Accepted writes push expected bytes; a monitor pops and
// compares on every read handshake.
module tb_bram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [4:0] level;
    logic       mem_cs;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem_array [16];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_rd_addr = 4'd0;
    logic [3:0] last_wr_addr = 4'd0;
    logic       rd_wrap_seen = 1'b0;
    logic       wr_wrap_seen = 1'b0;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .level(level),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Behavioural single-port BRAM with registered read data.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem_array[mem_addr] <= mem_din;
            else        mem_dout <= mem_array[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: compare every delivered word with the oldest expected.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected none", rd_data);
            end else begin
                check("rd_word", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Track BRAM address wrap for both fetches and writes.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_cs) begin
            if (mem_we) begin
                if (last_wr_addr == 4'd15 && mem_addr == 4'd0) wr_wrap_seen = 1'b1;
                last_wr_addr = mem_addr;
            end else begin
                if (last_rd_addr == 4'd15 && mem_addr == 4'd0) rd_wrap_seen = 1'b1;
                last_rd_addr = mem_addr;
            end
        end
    end

    task automatic push_word(input logic [7:0] d);
        bit done = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                exp_q.push_back(d);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no wr_ready expected handshake for 0x%0h", d);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || rd_valid) begin
            errors++;
            $display("FAIL %s: got %0d words pending expected 0", name, exp_q.size());
        end else begin
            $display("ok   %s: drained", name);
        end
    endtask

    initial begin
        logic [7:0] held;
        int         idx;
        int         acc;

        rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b0;

        // Reset: outputs gated even with wr_valid high.
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; wr_valid = 1'b0;
        @(negedge clk);
        check("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("post_rst_level", {27'd0, level}, 32'd0);
        check("post_rst_rd_data", {24'd0, rd_data}, 32'd0);

        // Single word, cycle-exact.
        rd_ready = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        check("sw_wr_cs", {31'd0, mem_cs}, 32'd1);
        check("sw_wr_we", {31'd0, mem_we}, 32'd1);
        check("sw_wr_addr", {28'd0, mem_addr}, 32'd0);
        check("sw_wr_din", {24'd0, mem_din}, 32'hA5);
        if (wr_ready) exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("sw_fetch_cs", {31'd0, mem_cs}, 32'd1);
        check("sw_fetch_we", {31'd0, mem_we}, 32'd0);
        check("sw_fetch_addr", {28'd0, mem_addr}, 32'd0);
        check("sw_fetch_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        check("sw_t2_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        check("sw_t3_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("sw_t3_rd_data", {24'd0, rd_data}, 32'hA5);
        check("sw_t3_level", {27'd0, level}, 32'd0);
        @(posedge clk); #1;
        wait_drain("sw_drain");

        // Fill with consumer stalled: 17 accepted out of 0x00..0x13.
        rd_ready = 1'b0;
        idx = 0; acc = 0;
        for (int c = 0; c < 60; c++) begin
            wr_data  = idx[7:0];
            wr_valid = (idx <= 8'h13);
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                exp_q.push_back(idx[7:0]);
                idx++;
                acc++;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        check("fill_accepted", acc, 32'd17);
        check("fill_level", {27'd0, level}, 32'd16);
        check("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("fill_rd_data", {24'd0, rd_data}, 32'h00);

        // Backpressure: output held, no fetch, writes ignored.
        held = rd_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_rd_data", {24'd0, rd_data}, {24'd0, held});
            check("bp_mem_cs", {31'd0, mem_cs}, 32'd0);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        wait_drain("fill_drain");
        @(negedge clk);
        check("fill_end_level", {27'd0, level}, 32'd0);

        // Wrap: 40 bytes with random write gaps.
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            push_word(8'h40 + i[7:0]);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_drain("wrap_drain");
        check("wrap_rd_addr", {31'd0, rd_wrap_seen}, 32'd1);
        check("wrap_wr_addr", {31'd0, wr_wrap_seen}, 32'd1);

        // Arbitration: writer held off for one fetch cycle, then completes.
        rd_ready = 1'b0;
        push_word(8'h51);
        push_word(8'h52);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0; wr_valid = 1'b1; wr_data = 8'h53;
        @(negedge clk);
        check("arb_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("arb_fetch_cs", {31'd0, mem_cs}, 32'd1);
        check("arb_fetch_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("arb_wr_we", {31'd0, mem_we}, 32'd1);
        check("arb_wr_din", {24'd0, mem_din}, 32'h53);
        if (wr_ready) exp_q.push_back(8'h53);
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_ready = 1'b1;
        wait_drain("arb_drain");

        // Reset during S_WAIT drops the in-flight word.
        rd_ready = 1'b0;
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 8'h99;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_wait_cs", {31'd0, mem_cs}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("mid_rst_level", {27'd0, level}, 32'd0);
        check("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("mid_rst_rd_data", {24'd0, rd_data}, 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        check("post_rst_wr_addr", {28'd0, mem_addr}, 32'd0);
        if (wr_ready) exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("post_rst_fetch_addr", {28'd0, mem_addr}, 32'd0);
        rd_ready = 1'b1;
        wait_drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
